// File: rtl/alu_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_control_unit_pkg
// Shared definitions for the ALU decode stage and the ALU itself: the R-type
// funct codes, the op classes coming from the main controller, the result
// mux encodings and the state enum of the MULTU sequencer.
// ---------------------------------------------------------------------------
package alu_control_unit_pkg;

    // R-type funct field values; the five ALU codes double as ALU function codes
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    // Op classes driven by the main controller
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    // Result mux select
    typedef enum logic [1:0] {
        OUT_ALU   = 2'b00,
        OUT_SHIFT = 2'b01,
        OUT_HI    = 2'b10,
        OUT_LO    = 2'b11
    } out_sel_e;

    // MULTU sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/alu_control_unit_if.sv
// ---------------------------------------------------------------------------
// alu_control_unit_if
// Bundle between the instruction source (master) and the ALU control unit
// (slave).
//   master drives : alu_op, funct, valid
//   slave drives  : alu_signal, shift_en, mul_start, mul_en, hilo_we,
//                   out_sel, busy, stall
// ---------------------------------------------------------------------------
interface alu_control_unit_if;

    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       valid;
    logic [5:0] alu_signal;
    logic       shift_en;
    logic       mul_start;
    logic       mul_en;
    logic       hilo_we;
    logic [1:0] out_sel;
    logic       busy;
    logic       stall;

    modport master (
        output alu_op, funct, valid,
        input  alu_signal, shift_en, mul_start, mul_en, hilo_we, out_sel, busy, stall
    );

    modport slave (
        input  alu_op, funct, valid,
        output alu_signal, shift_en, mul_start, mul_en, hilo_we, out_sel, busy, stall
    );

endinterface

// File: rtl/alu_control_unit_mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
// FSM plus iteration counter for the multi-cycle MULTU operation.
//   clk         : rising-edge clock
//   reset       : asynchronous, active-high reset
//   start_i     : a MULTU is presented; only acted on in IDLE
//   mul_start_o : LOAD state, multiplier loads operands
//   mul_en_o    : RUN state, one shift-add step per cycle
//   hilo_we_o   : DONE state, HI/LO latch the product
//   busy_o      : any state other than IDLE
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module mul_sequencer
    import alu_control_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic mul_start_o,
    output logic mul_en_o,
    output logic hilo_we_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers. Reset drops any sequence in flight, so a
    // partially computed product never reaches HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. LOAD clears the counter so every RUN phase starts
    // from zero; RUN leaves on the cycle the counter shows the final step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output strobes are pure functions of the state register.
    always_comb begin
        mul_start_o = (state_q == S_LOAD);
        mul_en_o    = (state_q == S_RUN);
        hilo_we_o   = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
    end

endmodule

// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
// Decode stage in front of the 32-bit ALU: turns op class + funct into the
// ALU function code, steers the shifter and result mux, and hands MULTU off
// to the multi-cycle sequencer while stalling HI/LO consumers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   ctrl  : slave side of alu_control_unit_if (alu_op/funct/valid in,
//           alu_signal/shift_en/mul_start/mul_en/hilo_we/out_sel/busy/stall out)
// ---------------------------------------------------------------------------
module alu_control_unit
    import alu_control_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    alu_control_unit_if.slave  ctrl
);

    logic isRType;
    logic issueMultu;
    logic needsHiLo;
    logic seqBusy;

    // Combinational decode. Only alu_op and funct matter here, so ALU and
    // shift instructions keep flowing while a MULTU is in progress. Any
    // funct without a defined meaning leaves everything at its idle value.
    always_comb begin
        ctrl.alu_signal = '0;
        ctrl.shift_en   = 1'b0;
        ctrl.out_sel    = OUT_ALU;
        case (ctrl.alu_op)
            OP_ADD: ctrl.alu_signal = F_ADD;
            OP_SUB: ctrl.alu_signal = F_SUB;
            OP_SLT: ctrl.alu_signal = F_SLT;
            OP_RTYPE: begin
                case (ctrl.funct)
                    F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
                        ctrl.alu_signal = ctrl.funct;
                    end
                    F_SRL: begin
                        ctrl.shift_en = 1'b1;
                        ctrl.out_sel  = OUT_SHIFT;
                    end
                    F_MFHI: ctrl.out_sel = OUT_HI;
                    F_MFLO: ctrl.out_sel = OUT_LO;
                    default: begin
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    // Hazard detection. While a sequence runs, anything touching HI/LO must
    // wait. A MULTU seen in IDLE is also stalled in its own issue cycle: the
    // sequencer has latched it, and holding the instruction keeps it off the
    // ALU until the product exists. Reset forces the stall low.
    always_comb begin
        isRType    = (ctrl.alu_op == OP_RTYPE);
        issueMultu = ctrl.valid && isRType && (ctrl.funct == F_MULTU);
        needsHiLo  = isRType && ((ctrl.funct == F_MULTU) ||
                                 (ctrl.funct == F_MFHI)  ||
                                 (ctrl.funct == F_MFLO));
        ctrl.stall = !reset &&
                     ((seqBusy && ctrl.valid && needsHiLo) || (!seqBusy && issueMultu));
        ctrl.busy  = seqBusy;
    end

    mul_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mul_sequencer (
        .clk         (clk),
        .reset       (reset),
        .start_i     (issueMultu),
        .mul_start_o (ctrl.mul_start),
        .mul_en_o    (ctrl.mul_en),
        .hilo_we_o   (ctrl.hilo_we),
        .busy_o      (seqBusy)
    );

endmodule

// File: tb/tb_alu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_control_unit
// Directed scenarios plus randomized traffic against a cycle-offset model of
// the ALU control unit. A single compare process checks every output on
// every falling edge; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_control_unit;

    localparam int MUL = 32;

    logic clk;
    logic reset;
    logic cmpEnable;
    int   testsRun;
    int   testsFailed;

    // Position inside a MULTU sequence: 0 = idle, 1 = load cycle,
    // 2..MUL+1 = multiply steps, MUL+2 = product write.
    int   seqPos;

    alu_control_unit_if ctrl ();

    alu_control_unit #(
        .MUL_CYCLES (MUL),
        .CNT_W      (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record one comparison and report it if it disagrees
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drive one instruction slot
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f);
        ctrl.valid  = v;
        ctrl.alu_op = op;
        ctrl.funct  = f;
    endtask

    // Advance to just after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference decode straight from the instruction table
    function automatic void refDecode(input logic [1:0] op, input logic [5:0] f,
                                      output int sig, output int sh, output int sel);
        sig = 0;
        sh  = 0;
        sel = 0;
        if (op == 2'd0) sig = 32;
        else if (op == 2'd1) sig = 34;
        else if (op == 2'd3) sig = 42;
        else begin
            if (f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42}) sig = int'(f);
            if (f == 6'd2) begin
                sh  = 1;
                sel = 1;
            end
            if (f == 6'd16) sel = 2;
            if (f == 6'd18) sel = 3;
        end
    endfunction

    // Sequence position model: a MULTU seen while idle starts a sequence of
    // MUL+2 cycles; reset discards it immediately.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            seqPos <= 0;
        end else if (seqPos != 0) begin
            seqPos <= (seqPos == MUL + 2) ? 0 : seqPos + 1;
        end else if (ctrl.valid && ctrl.alu_op == 2'd2 && ctrl.funct == 6'd25) begin
            seqPos <= 1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int sig, sh, sel;
        bit expBusy, hiLoFunct, multu, expStall;
        if (cmpEnable) begin
            refDecode(ctrl.alu_op, ctrl.funct, sig, sh, sel);
            expBusy   = (seqPos != 0);
            hiLoFunct = (ctrl.alu_op == 2'd2) && (ctrl.funct inside {6'd25, 6'd16, 6'd18});
            multu     = ctrl.valid && (ctrl.alu_op == 2'd2) && (ctrl.funct == 6'd25);
            expStall  = !reset && ((expBusy && ctrl.valid && hiLoFunct) || (!expBusy && multu));
            checkOutput("alu_signal", int'(ctrl.alu_signal), sig);
            checkOutput("shift_en",   int'(ctrl.shift_en),   sh);
            checkOutput("out_sel",    int'(ctrl.out_sel),    sel);
            checkOutput("mul_start",  int'(ctrl.mul_start),  int'(seqPos == 1));
            checkOutput("mul_en",     int'(ctrl.mul_en),     int'(seqPos >= 2 && seqPos <= MUL + 1));
            checkOutput("hilo_we",    int'(ctrl.hilo_we),    int'(seqPos == MUL + 2));
            checkOutput("busy",       int'(ctrl.busy),       int'(expBusy));
            checkOutput("stall",      int'(ctrl.stall),      int'(expStall));
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int aluTable [5];
        int pickTable [10];
        int enCount;
        int hiloCount;
        int hiloAt;
        aluTable  = '{36, 37, 32, 34, 42};
        pickTable = '{36, 37, 32, 34, 42, 2, 25, 16, 18, 0};
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 2'd0, 6'd0);
        cmpEnable   = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset busy",    int'(ctrl.busy),    0);
        checkOutput("reset mul_en",  int'(ctrl.mul_en),  0);
        checkOutput("reset hilo_we", int'(ctrl.hilo_we), 0);
        stepCycle();
        reset = 1'b0;
        stepCycle();

        // Decode of legal ALU functs and the fixed op classes
        foreach (aluTable[i]) begin
            applyStimulus(1'b1, 2'd2, 6'(aluTable[i]));
            @(negedge clk);
            checkOutput("t1 rtype alu_signal", int'(ctrl.alu_signal), aluTable[i]);
            checkOutput("t1 rtype out_sel",    int'(ctrl.out_sel),    0);
            checkOutput("t1 rtype busy",       int'(ctrl.busy),       0);
            stepCycle();
        end
        applyStimulus(1'b1, 2'd0, 6'($urandom_range(0, 63)));
        @(negedge clk);
        checkOutput("t1 op00", int'(ctrl.alu_signal), 32);
        stepCycle();
        applyStimulus(1'b1, 2'd1, 6'($urandom_range(0, 63)));
        @(negedge clk);
        checkOutput("t1 op01", int'(ctrl.alu_signal), 34);
        stepCycle();
        applyStimulus(1'b1, 2'd3, 6'($urandom_range(0, 63)));
        @(negedge clk);
        checkOutput("t1 op11", int'(ctrl.alu_signal), 42);
        stepCycle();

        // Single MULTU, then an ADD and a held MFLO during the sequence
        applyStimulus(1'b1, 2'd2, 6'd25);
        @(negedge clk);
        checkOutput("t2 issue stall", int'(ctrl.stall), 1);
        checkOutput("t2 issue busy",  int'(ctrl.busy),  0);
        stepCycle();
        enCount = 0;
        for (int k = 1; k <= MUL + 3; k++) begin
            if (k < 7)       applyStimulus(1'b0, 2'd0, 6'd0);
            else if (k == 7) applyStimulus(1'b1, 2'd2, 6'd32);
            else             applyStimulus(1'b1, 2'd2, 6'd18);
            @(negedge clk);
            if (ctrl.mul_en) enCount++;
            checkOutput("t2 mul_start", int'(ctrl.mul_start), int'(k == 1));
            checkOutput("t2 hilo_we",   int'(ctrl.hilo_we),   int'(k == MUL + 2));
            checkOutput("t2 busy",      int'(ctrl.busy),      int'(k <= MUL + 2));
            if (k == 7) begin
                checkOutput("t3 add alu_signal", int'(ctrl.alu_signal), 32);
                checkOutput("t3 add stall",      int'(ctrl.stall),      0);
            end
            if (k >= 8 && k <= MUL + 2) checkOutput("t3 mflo stall", int'(ctrl.stall), 1);
            if (k == MUL + 3) begin
                checkOutput("t3 mflo release stall", int'(ctrl.stall),   0);
                checkOutput("t3 mflo out_sel",       int'(ctrl.out_sel), 3);
            end
            stepCycle();
        end
        checkOutput("t2 mul_en cycles", enCount, MUL);
        applyStimulus(1'b0, 2'd0, 6'd0);
        stepCycle();

        // Back-to-back MULTUs: the second is held until the idle gap
        applyStimulus(1'b1, 2'd2, 6'd25);
        stepCycle();
        hiloCount = 0;
        for (int k = 1; k <= 2 * MUL + 8; k++) begin
            if (k <= MUL + 3) applyStimulus(1'b1, 2'd2, 6'd25);
            else              applyStimulus(1'b0, 2'd0, 6'd0);
            @(negedge clk);
            if (ctrl.hilo_we) hiloCount++;
            if (k <= MUL + 2) checkOutput("t4 held stall", int'(ctrl.stall), 1);
            if (k == MUL + 3) checkOutput("t4 idle gap busy", int'(ctrl.busy), 0);
            if (k == MUL + 4) checkOutput("t4 second load", int'(ctrl.mul_start), 1);
            stepCycle();
        end
        checkOutput("t4 hilo pulses", hiloCount, 2);

        // Asynchronous reset in the middle of the multiply steps
        applyStimulus(1'b1, 2'd2, 6'd25);
        stepCycle();
        applyStimulus(1'b0, 2'd0, 6'd0);
        repeat (18) stepCycle();
        @(negedge clk);
        checkOutput("t5 running before reset", int'(ctrl.mul_en), 1);
        applyStimulus(1'b1, 2'd2, 6'd25);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5 async mul_start", int'(ctrl.mul_start), 0);
        checkOutput("t5 async mul_en",    int'(ctrl.mul_en),    0);
        checkOutput("t5 async hilo_we",   int'(ctrl.hilo_we),   0);
        checkOutput("t5 async busy",      int'(ctrl.busy),      0);
        checkOutput("t5 async stall",     int'(ctrl.stall),     0);
        stepCycle();
        applyStimulus(1'b0, 2'd0, 6'd0);
        reset = 1'b0;
        hiloCount = 0;
        repeat (MUL + 4) begin
            @(negedge clk);
            if (ctrl.hilo_we) hiloCount++;
            stepCycle();
        end
        checkOutput("t5 no hilo after reset", hiloCount, 0);
        applyStimulus(1'b1, 2'd2, 6'd25);
        stepCycle();
        applyStimulus(1'b0, 2'd0, 6'd0);
        enCount = 0;
        hiloAt  = -1;
        for (int k = 1; k <= MUL + 3; k++) begin
            @(negedge clk);
            if (ctrl.mul_en) enCount++;
            if (ctrl.hilo_we) hiloAt = k;
            stepCycle();
        end
        checkOutput("t5 restart mul_en cycles", enCount, MUL);
        checkOutput("t5 restart hilo offset",   hiloAt,  MUL + 2);

        // Undefined functs do nothing
        applyStimulus(1'b1, 2'd2, 6'd0);
        @(negedge clk);
        checkOutput("t6 nop alu_signal", int'(ctrl.alu_signal), 0);
        checkOutput("t6 nop shift_en",   int'(ctrl.shift_en),   0);
        stepCycle();
        applyStimulus(1'b1, 2'd2, 6'd63);
        @(negedge clk);
        checkOutput("t6 f63 alu_signal", int'(ctrl.alu_signal), 0);
        checkOutput("t6 f63 out_sel",    int'(ctrl.out_sel),    0);
        checkOutput("t6 nop stays idle", int'(ctrl.busy),       0);
        stepCycle();

        // Randomized traffic with occasional holds and asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [5:0] f;
                if ($urandom_range(0, 9) < 6) f = 6'(pickTable[$urandom_range(0, 9)]);
                else                          f = 6'($urandom_range(0, 63));
                applyStimulus(1'($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), f);
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end else begin
                stepCycle();
            end
        end

        applyStimulus(1'b0, 2'd0, 6'd0);
        stepCycle();
        cmpEnable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
